song_sequencer: RTL

Drives the note player's load interface from a song stored in ROM.
- Fetches 16-bit song words sequentially and decodes note, rest, jump, repeat and end commands.
- For each note, pulses a one-cycle load with pitch/duration/instrument, then waits the note's duration in frame strobes before fetching the next word.
- Sits between the frame timer and the note player.
- Owns its own ROM port; an external arbiter or a dedicated song ROM serves that port.

---
 rtl/song_sequencer_pkg.sv | 41 ++++
 rtl/song_word_decode.sv | 44 ++++
 rtl/song_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer and the note player.
// Holds song word field positions, control opcodes, field widths,
// the decoded word type and the sequencer state encoding.
package song_sequencer_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned PITCH_W = 6;
  localparam int unsigned DUR_W   = 5;
  localparam int unsigned INSTR_W = 4;
  localparam int unsigned COUNT_W = 5;

  // Field positions inside a song word
  localparam int unsigned CTRL_BIT  = 15;
  localparam int unsigned PITCH_LSB = 0;
  localparam int unsigned DUR_LSB   = 6;
  localparam int unsigned INSTR_LSB = 11;
  localparam int unsigned COUNT_LSB = 8;
  localparam int unsigned CMD_LSB   = 13;

  // Control opcodes, word[14:13] when word[15] is set
  localparam logic [1:0] CMD_END    = 2'b00;
  localparam logic [1:0] CMD_JUMP   = 2'b01;
  localparam logic [1:0] CMD_REST   = 2'b10;
  localparam logic [1:0] CMD_REPEAT = 2'b11;

  typedef enum logic [2:0] {
    WordNote,
    WordRest,
    WordJump,
    WordRepeat,
    WordEnd
  } word_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDecode,
    StWait
  } seq_state_e;

endpackage

// File: rtl/song_word_decode.sv
// Combinational split of a 16-bit song word into its type and fields.
// Ports:
//   i_word       song word from ROM
//   o_type       NOTE / REST / JUMP / REPEAT / END
//   o_pitch      note pitch            [5:0]
//   o_duration   note or rest duration [10:6]
//   o_instrument note instrument       [14:11]
//   o_target     jump / repeat target  [ADDR_W-1:0]
//   o_count      repeat count          [12:8]
module song_word_decode
  import song_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [WORD_W-1:0]  i_word,
  output word_type_e         o_type,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [DUR_W-1:0]   o_duration,
  output logic [INSTR_W-1:0] o_instrument,
  output logic [ADDR_W-1:0]  o_target,
  output logic [COUNT_W-1:0] o_count
);

  always_comb begin
    o_pitch      = i_word[PITCH_LSB +: PITCH_W];
    o_duration   = i_word[DUR_LSB +: DUR_W];
    o_instrument = i_word[INSTR_LSB +: INSTR_W];
    o_target     = i_word[ADDR_W-1:0];
    o_count      = i_word[COUNT_LSB +: COUNT_W];
    o_type       = WordEnd;
    if (!i_word[CTRL_BIT]) begin
      o_type = WordNote;
    end else begin
      unique case (i_word[CMD_LSB +: 2])
        CMD_END:    o_type = WordEnd;
        CMD_JUMP:   o_type = WordJump;
        CMD_REST:   o_type = WordRest;
        CMD_REPEAT: o_type = WordRepeat;
        default:    o_type = WordEnd;
      endcase
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Plays a song stored in ROM into the note player's load interface.
// Fetches words sequentially, issues one-cycle loads for notes and waits
// each note/rest for duration+1 frame strobes.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_stb           one-cycle frame tick
//   i_start / i_stop      begin playback at i_song_base / abort playback
//   o_rom_addr            registered ROM address; i_rom_data answers it
//   o_load                one-cycle load pulse, fields valid with it and held
//   o_pitch/o_duration/o_instrument  held note fields
//   o_busy                high from the cycle after start through o_done
//   o_done                one-cycle pulse on END
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_frame_stb,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [ADDR_W-1:0]  i_song_base,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [WORD_W-1:0]  i_rom_data,
  output logic               o_load,
  output logic [PITCH_W-1:0] o_pitch,
  output logic [DUR_W-1:0]   o_duration,
  output logic [INSTR_W-1:0] o_instrument,
  output logic               o_busy,
  output logic               o_done
);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [PITCH_W-1:0] pitch_q, pitch_d;
  logic [DUR_W-1:0]   duration_q, duration_d;
  logic [INSTR_W-1:0] instrument_q, instrument_d;
  logic [DUR_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [COUNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic               loop_active_q, loop_active_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  word_type_e         dec_type;
  logic [PITCH_W-1:0] dec_pitch;
  logic [DUR_W-1:0]   dec_duration;
  logic [INSTR_W-1:0] dec_instrument;
  logic [ADDR_W-1:0]  dec_target;
  logic [COUNT_W-1:0] dec_count;

  logic [ADDR_W-1:0]  pc_inc;
  logic [COUNT_W-1:0] eff_cnt;

  song_word_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .i_word       (i_rom_data),
    .o_type       (dec_type),
    .o_pitch      (dec_pitch),
    .o_duration   (dec_duration),
    .o_instrument (dec_instrument),
    .o_target     (dec_target),
    .o_count      (dec_count)
  );

  assign pc_inc  = pc_q + ADDR_W'(1);
  // A REPEAT seen with no loop armed uses its own count; an armed loop
  // (including a nested REPEAT) works on the shared counter.
  assign eff_cnt = loop_active_q ? loop_cnt_q : dec_count;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rom_addr_d    = rom_addr_q;
    pitch_d       = pitch_q;
    duration_d    = duration_q;
    instrument_d  = instrument_q;
    frame_cnt_d   = frame_cnt_q;
    loop_cnt_d    = loop_cnt_q;
    loop_active_d = loop_active_q;
    load_d        = 1'b0;
    done_d        = 1'b0;

    if (i_stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            pc_d          = i_song_base;
            loop_cnt_d    = '0;
            loop_active_d = 1'b0;
            state_d       = StFetch;
          end
        end
        StFetch: begin
          rom_addr_d = pc_q;
          state_d    = StDecode;
        end
        StDecode: begin
          unique case (dec_type)
            WordNote: begin
              pitch_d      = dec_pitch;
              duration_d   = dec_duration;
              instrument_d = dec_instrument;
              load_d       = 1'b1;
              frame_cnt_d  = dec_duration;
              pc_d         = pc_inc;
              state_d      = StWait;
            end
            WordRest: begin
              frame_cnt_d = dec_duration;
              pc_d        = pc_inc;
              state_d     = StWait;
            end
            WordJump: begin
              pc_d    = dec_target;
              state_d = StFetch;
            end
            WordRepeat: begin
              if (eff_cnt != '0) begin
                loop_cnt_d    = eff_cnt - COUNT_W'(1);
                loop_active_d = 1'b1;
                pc_d          = dec_target;
              end else begin
                loop_cnt_d    = eff_cnt;
                loop_active_d = 1'b0;
                pc_d          = pc_inc;
              end
              state_d = StFetch;
            end
            default: begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          endcase
        end
        StWait: begin
          if (i_frame_stb) begin
            if (frame_cnt_q == '0) begin
              state_d = StFetch;
            end else begin
              frame_cnt_d = frame_cnt_q - DUR_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Busy stays up through the done pulse, drops the cycle after.
    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      rom_addr_q    <= '0;
      pitch_q       <= '0;
      duration_q    <= '0;
      instrument_q  <= '0;
      frame_cnt_q   <= '0;
      loop_cnt_q    <= '0;
      loop_active_q <= 1'b0;
      load_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_addr_q    <= rom_addr_d;
      pitch_q       <= pitch_d;
      duration_q    <= duration_d;
      instrument_q  <= instrument_d;
      frame_cnt_q   <= frame_cnt_d;
      loop_cnt_q    <= loop_cnt_d;
      loop_active_q <= loop_active_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign o_rom_addr   = rom_addr_q;
  assign o_pitch      = pitch_q;
  assign o_duration   = duration_q;
  assign o_instrument = instrument_q;
  assign o_load       = load_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
